// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Consumer stage behind ps2_keyboard. It pops one byte per 3 cycles from the
// receiver FIFO and decodes PS/2 set-2 make, break (F0) and extended (E0)
// sequences. It tracks the single held key, flags typematic repeats, and
// reports each event with a registered code, ASCII and a one-cycle strobe.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   data, ready   FIFO head byte and FIFO non-empty flag
//   overflow      FIFO overflow flag, captured sticky into err_overflow
//   nextdata_n    active-low pop request, low for one cycle per byte
//   key_code      scan code of the last event
//   key_ext       last event carried the E0 prefix
//   key_ascii     ASCII of key_code, 0x00 for extended/unmapped codes
//   key_valid     a key is currently held
//   key_event     one-cycle strobe when the event outputs update
//   key_break     last event was a release
//   key_repeat    last event was a typematic repeat
//   press_cnt     distinct key presses, modulo 256
//   err_overflow  sticky overflow flag
module ps2_scancode_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       ready,
    input  logic       overflow,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic [7:0] key_ascii,
    output logic       key_valid,
    output logic       key_event,
    output logic       key_break,
    output logic       key_repeat,
    output logic [7:0] press_cnt,
    output logic       err_overflow
);
    typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

    state_t     state_q;
    logic [7:0] byte_q;
    logic       brk_pend_q, ext_pend_q;
    logic [7:0] held_code_q;
    logic       held_ext_q;
    logic       nextdata_n_q;
    logic [7:0] key_code_q, key_ascii_q, press_cnt_q;
    logic       key_ext_q, key_valid_q, key_event_q;
    logic       key_break_q, key_repeat_q, err_overflow_q;

    logic [7:0] ascii_d;
    logic       hit_d;

    // Non-extended set-2 code to ASCII.
    always_comb begin
        ascii_d = 8'h00;
        case (byte_q)
            8'h1C: ascii_d = 8'h61; 8'h32: ascii_d = 8'h62; 8'h21: ascii_d = 8'h63;
            8'h23: ascii_d = 8'h64; 8'h24: ascii_d = 8'h65; 8'h2B: ascii_d = 8'h66;
            8'h34: ascii_d = 8'h67; 8'h33: ascii_d = 8'h68; 8'h43: ascii_d = 8'h69;
            8'h3B: ascii_d = 8'h6A; 8'h42: ascii_d = 8'h6B; 8'h4B: ascii_d = 8'h6C;
            8'h3A: ascii_d = 8'h6D; 8'h31: ascii_d = 8'h6E; 8'h44: ascii_d = 8'h6F;
            8'h4D: ascii_d = 8'h70; 8'h15: ascii_d = 8'h71; 8'h2D: ascii_d = 8'h72;
            8'h1B: ascii_d = 8'h73; 8'h2C: ascii_d = 8'h74; 8'h3C: ascii_d = 8'h75;
            8'h2A: ascii_d = 8'h76; 8'h1D: ascii_d = 8'h77; 8'h22: ascii_d = 8'h78;
            8'h35: ascii_d = 8'h79; 8'h1A: ascii_d = 8'h7A;
            8'h45: ascii_d = 8'h30; 8'h16: ascii_d = 8'h31; 8'h1E: ascii_d = 8'h32;
            8'h26: ascii_d = 8'h33; 8'h25: ascii_d = 8'h34; 8'h2E: ascii_d = 8'h35;
            8'h36: ascii_d = 8'h36; 8'h3D: ascii_d = 8'h37; 8'h3E: ascii_d = 8'h38;
            8'h46: ascii_d = 8'h39;
            8'h29: ascii_d = 8'h20; 8'h5A: ascii_d = 8'h0D;
            default: ascii_d = 8'h00;
        endcase
    end

    // Current byte (with its pending E0) names the held key.
    assign hit_d = key_valid_q && (byte_q == held_code_q) && (ext_pend_q == held_ext_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            byte_q         <= 8'h00;
            brk_pend_q     <= 1'b0;
            ext_pend_q     <= 1'b0;
            held_code_q    <= 8'h00;
            held_ext_q     <= 1'b0;
            nextdata_n_q   <= 1'b1;
            key_code_q     <= 8'h00;
            key_ascii_q    <= 8'h00;
            press_cnt_q    <= 8'h00;
            key_ext_q      <= 1'b0;
            key_valid_q    <= 1'b0;
            key_event_q    <= 1'b0;
            key_break_q    <= 1'b0;
            key_repeat_q   <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            key_event_q <= 1'b0;
            if (overflow) err_overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (ready) begin
                        byte_q  <= data;
                        state_q <= POP;
                    end
                end
                POP: begin
                    nextdata_n_q <= 1'b0;
                    state_q      <= DECODE;
                end
                DECODE: begin
                    nextdata_n_q <= 1'b1;
                    state_q      <= IDLE;
                    if (byte_q == 8'hF0) begin
                        brk_pend_q <= 1'b1;
                    end else if (byte_q == 8'hE0) begin
                        ext_pend_q <= 1'b1;
                    end else begin
                        key_event_q <= 1'b1;
                        key_code_q  <= byte_q;
                        key_ext_q   <= ext_pend_q;
                        key_ascii_q <= ext_pend_q ? 8'h00 : ascii_d;
                        brk_pend_q  <= 1'b0;
                        ext_pend_q  <= 1'b0;
                        if (brk_pend_q) begin
                            // Release of a non-held key leaves the held key alone.
                            key_break_q  <= 1'b1;
                            key_repeat_q <= 1'b0;
                            if (hit_d) key_valid_q <= 1'b0;
                        end else if (hit_d) begin
                            key_break_q  <= 1'b0;
                            key_repeat_q <= 1'b1;
                        end else begin
                            held_code_q  <= byte_q;
                            held_ext_q   <= ext_pend_q;
                            key_valid_q  <= 1'b1;
                            press_cnt_q  <= press_cnt_q + 8'd1;
                            key_break_q  <= 1'b0;
                            key_repeat_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign nextdata_n   = nextdata_n_q;
    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign key_ascii    = key_ascii_q;
    assign key_valid    = key_valid_q;
    assign key_event    = key_event_q;
    assign key_break    = key_break_q;
    assign key_repeat   = key_repeat_q;
    assign press_cnt    = press_cnt_q;
    assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow = 1'b0;
    logic       nextdata_n;
    logic [7:0] key_code, key_ascii, press_cnt;
    logic       key_ext, key_valid, key_event, key_break, key_repeat, err_overflow;

    int nerr = 0;
    int nchk = 0;

    // Small FIFO standing in for ps2_keyboard; pops when nextdata_n is low.
    logic [7:0] fifo [16];
    logic [3:0] wp = 4'd0;
    logic [3:0] rp = 4'd0;
    assign ready = (wp != rp);
    assign data  = fifo[rp];
    always @(posedge clk) if (!nextdata_n && (wp != rp)) rp <= rp + 4'd1;

    always #5 clk = ~clk;

    ps2_scancode_decoder dut (
        .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
        .key_ascii(key_ascii), .key_valid(key_valid), .key_event(key_event),
        .key_break(key_break), .key_repeat(key_repeat), .press_cnt(press_cnt),
        .err_overflow(err_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo[wp] = b;
        wp = wp + 4'd1;
    endtask

    // Push one byte and move to the cycle where its event strobe must be.
    task automatic feed(input logic [7:0] b);
        push(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_ev(input string tag, input logic [7:0] code, input logic ext,
                          input logic [7:0] asc, input logic vld, input logic brk,
                          input logic rep, input logic [7:0] cnt);
        chk({tag, ".event"},  key_event, 1'b1);
        chk({tag, ".code"},   key_code, code);
        chk({tag, ".ext"},    key_ext, ext);
        chk({tag, ".ascii"},  key_ascii, asc);
        chk({tag, ".valid"},  key_valid, vld);
        chk({tag, ".break"},  key_break, brk);
        chk({tag, ".repeat"}, key_repeat, rep);
        chk({tag, ".cnt"},    press_cnt, cnt);
    endtask

    initial begin
        int lows, first, last, gap_bad, evs, ev1, ev2;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst.nextdata_n", nextdata_n, 1'b1);
        chk("rst.code", key_code, 8'h00);
        chk("rst.valid", key_valid, 1'b0);
        chk("rst.event", key_event, 1'b0);
        chk("rst.cnt", press_cnt, 8'h00);
        chk("rst.err", err_overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Make then break of 'a'
        feed(8'h1C); chk_ev("mk_a", 8'h1C, 0, 8'h61, 1, 0, 0, 8'd1);
        @(negedge clk); chk("mk_a.strobe_one_cycle", key_event, 1'b0);
        feed(8'hF0); chk("f0.no_event", key_event, 1'b0);
        feed(8'h1C); chk_ev("brk_a", 8'h1C, 0, 8'h61, 0, 1, 0, 8'd1);

        // Typematic repeat
        do_reset();
        feed(8'h1C); chk_ev("rep1", 8'h1C, 0, 8'h61, 1, 0, 0, 8'd1);
        feed(8'h1C); chk_ev("rep2", 8'h1C, 0, 8'h61, 1, 0, 1, 8'd1);
        feed(8'h1C); chk_ev("rep3", 8'h1C, 0, 8'h61, 1, 0, 1, 8'd1);

        // Extended key make/break
        do_reset();
        feed(8'hE0); chk("e0.no_event", key_event, 1'b0);
        feed(8'h75); chk_ev("ext_mk", 8'h75, 1, 8'h00, 1, 0, 0, 8'd1);
        feed(8'hE0); feed(8'hF0); chk("e0f0.no_event", key_event, 1'b0);
        feed(8'h75); chk_ev("ext_brk", 8'h75, 1, 8'h00, 0, 1, 0, 8'd1);
        // Non-extended 75 is a different key from E0 75: new press
        feed(8'h75); chk_ev("plain75", 8'h75, 0, 8'h00, 1, 0, 0, 8'd2);

        // Break of a non-held key keeps the held key
        do_reset();
        feed(8'h1C);
        feed(8'hF0); feed(8'h1B); chk_ev("brk_other", 8'h1B, 0, 8'h73, 1, 1, 0, 8'd1);
        feed(8'h1C); chk_ev("still_held", 8'h1C, 0, 8'h61, 1, 0, 1, 8'd1);

        // press_cnt wrap
        do_reset();
        for (int i = 0; i < 255; i++) feed((i % 2 == 0) ? 8'h1C : 8'h1B);
        chk("cnt.255", press_cnt, 8'd255);
        feed(8'h1B);
        chk("cnt.wrap", press_cnt, 8'd0);
        chk("cnt.wrap_event", key_event, 1'b1);

        // Sticky overflow
        overflow = 1'b1; @(negedge clk); overflow = 1'b0;
        chk("ovf.set", err_overflow, 1'b1);
        repeat (5) @(negedge clk);
        chk("ovf.sticky", err_overflow, 1'b1);
        do_reset();
        chk("ovf.cleared", err_overflow, 1'b0);

        // Handshake: three bytes preloaded with ready held high
        push(8'h15); push(8'hF0); push(8'h15);
        lows = 0; first = -1; last = 0; gap_bad = 0; evs = 0; ev1 = 0; ev2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!nextdata_n) begin
                lows++;
                if (first < 0) first = k;
                else if (k - last != 3) gap_bad++;
                last = k;
            end
            if (key_event) begin
                evs++;
                if (evs == 1) begin
                    ev1 = k;
                    chk("hs.q_ascii", key_ascii, 8'h71);
                end else ev2 = k;
            end
        end
        chk("hs.pops", lows, 3);
        chk("hs.first_pop", first, 2);
        chk("hs.spacing", gap_bad, 0);
        chk("hs.events", evs, 2);
        chk("hs.ev1_cycle", ev1, 3);
        chk("hs.ev2_cycle", ev2, 9);
        chk("hs.final_break", key_break, 1'b1);
        chk("hs.final_valid", key_valid, 1'b0);
        chk("hs.fifo_empty", ready, 1'b0);

        // Reset clears a pending break prefix
        feed(8'hF0);
        do_reset();
        feed(8'h1C); chk_ev("rst_pend", 8'h1C, 0, 8'h61, 1, 0, 0, 8'd1);

        // Extra ASCII rows: digit zero, space, enter
        feed(8'h45); chk("asc.0", key_ascii, 8'h30);
        feed(8'h29); chk("asc.space", key_ascii, 8'h20);
        feed(8'h5A); chk("asc.enter", key_ascii, 8'h0D);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
